// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by imem_loader and its producer.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 11
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words into instruction memory.
// Optional trailing 8-bit checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CSUM   = 3'd4,
`endif
    DONE   = 3'd5
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              begin_session;
  logic [7:0]        len_lo;
  logic [16:0]       len_full;
  logic              len_bad;
  logic              fail;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] last_addr;
  logic              word_done;
  logic              last_word;

  assign accept        = bus.byte_valid & bus.byte_ready;
  assign begin_session = (state == IDLE) && start;
  assign len_full      = {1'b0, bus.byte_data, len_lo};
  assign len_bad       = (len_full == 17'd0) || (len_full > MAX_WORDS);
  assign word_done     = accept && (state == DATA) && (byte_idx == 2'd3);
  // N is range-checked, so N-1 always fits in the word address
  assign last_word     = word_done && (waddr == last_addr);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_ok;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign sum_ok = (csum_add(sum, bus.byte_data) == 8'd0);
  assign fail   = accept && (((state == LEN_HI) && len_bad) || ((state == CSUM) && !sum_ok));
`else
  assign fail   = accept && (state == LEN_HI) && len_bad;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_LO;
        else       state_nxt = IDLE;
      end
      LEN_LO: begin
        if (accept) state_nxt = LEN_HI;
        else        state_nxt = LEN_LO;
      end
      LEN_HI: begin
        if (accept && len_bad) state_nxt = IDLE;
        else if (accept)       state_nxt = DATA;
        else                   state_nxt = LEN_HI;
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_word) state_nxt = CSUM;
        else           state_nxt = DATA;
`else
        if (last_word) state_nxt = DONE;
        else           state_nxt = DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept && sum_ok) state_nxt = DONE;
        else if (accept)      state_nxt = IDLE;
        else                  state_nxt = CSUM;
      end
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Session status outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.byte_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      core_hold      <= 1'b0;
    end else begin
`ifdef LOADER_CHECKSUM_EN
      bus.byte_ready <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                        (state_nxt == DATA)   || (state_nxt == CSUM);
`else
      bus.byte_ready <= (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                        (state_nxt == DATA);
`endif
      busy <= (state_nxt != IDLE);
      done <= (state == DONE);
      if (begin_session) begin
        err       <= 1'b0;
        core_hold <= 1'b1;
      end else begin
        // release the core one cycle after the done pulse; failures keep it held
        if (done) core_hold <= 1'b0;
        if (fail) err <= 1'b1;
      end
    end
  end

  // Length capture, word assembly and memory write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo      <= 8'd0;
      last_addr   <= {ADDR_W{1'b0}};
      byte_idx    <= 2'd0;
      word_buf    <= 24'd0;
      waddr       <= {ADDR_W{1'b0}};
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= {ADDR_W{1'b0}};
      bus.wr_data <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= 8'd0;
`endif
    end else begin
      bus.wr_en <= word_done;
      if (begin_session) begin
        waddr    <= {ADDR_W{1'b0}};
        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        sum      <= 8'd0;
`endif
      end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        sum <= csum_add(sum, bus.byte_data);
`endif
        case (state)
          LEN_LO: len_lo <= bus.byte_data;
          LEN_HI: last_addr <= ADDR_W'(len_full - 17'd1);
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            // little-endian: earlier bytes shift toward bit 0
            word_buf <= {bus.byte_data, word_buf[23:8]};
            if (byte_idx == 2'd3) begin
              bus.wr_addr <= waddr;
              bus.wr_data <= {bus.byte_data, word_buf};
              waddr       <= waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
